// File: rtl/btb_pkg.sv
// btb_pkg: shared counter encodings and entry metadata for the branch target buffer.
package btb_pkg;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } ctr_e;

    localparam ctr_e CTR_ALLOC = WT;
    localparam ctr_e CTR_RESET = WNT;

    // Tag and target widths depend on the instance parameters, so they live in
    // separate arrays beside this record.
    typedef struct packed {
        logic valid;
        ctr_e ctr;
    } btb_meta_t;

endpackage

// File: rtl/btb_sat_counter.sv
// btb_sat_counter: combinational next state of a 2-bit saturating branch counter.
module btb_sat_counter
    import btb_pkg::*;
(
    input  ctr_e ctr_i,
    input  logic taken_i,
    output ctr_e ctr_o
);

    always_comb begin
        ctr_o = taken_i ? ((ctr_i == ST)  ? ST  : ctr_e'(ctr_i + 2'd1))
                        : ((ctr_i == SNT) ? SNT : ctr_e'(ctr_i - 2'd1));
    end

endmodule

// File: rtl/branch_target_buffer.sv
// branch_target_buffer: direct-mapped BTB with 2-bit counters and mispredict redirect.
// Optional performance counters are enabled by defining BTB_STATS_EN.
module branch_target_buffer
    import btb_pkg::*;
#(
    parameter int PC_W    = 32,
    parameter int ENTRIES = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic [PC_W-1:0] lookup_pc,
    output logic            pred_taken,
    output logic [PC_W-1:0] pred_target,
    input  logic            upd_valid,
    input  logic            upd_is_branch,
    input  logic [PC_W-1:0] upd_pc,
    input  logic [PC_W-1:0] upd_target,
    input  logic            upd_taken,
    input  logic            upd_prev_taken,
    input  logic [PC_W-1:0] upd_pred_target,
    output logic            flush,
    output logic [PC_W-1:0] redirect_pc,
    output logic [31:0]     stat_lookups,
    output logic [31:0]     stat_mispredicts
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = PC_W - 2 - IDX_W;

    btb_meta_t       meta_q [ENTRIES];
    logic [TAG_W-1:0] tag_q [ENTRIES];
    logic [PC_W-1:0]  tgt_q [ENTRIES];

    logic [IDX_W-1:0] l_idx, u_idx;
    logic [TAG_W-1:0] l_tag, u_tag;
    logic             l_hit, u_hit;
    logic             br_upd, fill_we, meta_we;
    btb_meta_t        meta_d;
    ctr_e             ctr_nxt;

    assign l_idx = lookup_pc[IDX_W+1:2];
    assign l_tag = lookup_pc[PC_W-1:IDX_W+2];
    assign u_idx = upd_pc[IDX_W+1:2];
    assign u_tag = upd_pc[PC_W-1:IDX_W+2];
    assign l_hit = meta_q[l_idx].valid && (tag_q[l_idx] == l_tag);
    assign u_hit = meta_q[u_idx].valid && (tag_q[u_idx] == u_tag);

    // Lookup reads the registered table, so a same-cycle update is not visible yet.
    assign pred_taken  = l_hit && meta_q[l_idx].ctr[1];
    assign pred_target = l_hit ? tgt_q[l_idx] : lookup_pc + PC_W'(4);

    assign flush = upd_valid && (upd_is_branch
                   ? ((upd_taken != upd_prev_taken) ||
                      (upd_taken && upd_prev_taken && (upd_target != upd_pred_target)))
                   : upd_prev_taken);
    assign redirect_pc = (upd_is_branch && upd_taken) ? upd_target : upd_pc + PC_W'(4);

    btb_sat_counter u_ctr (
        .ctr_i   (meta_q[u_idx].ctr),
        .taken_i (upd_taken),
        .ctr_o   (ctr_nxt)
    );

    // A non-branch that was predicted taken aliased onto a branch entry: evict it.
    always_comb begin
        br_upd  = upd_valid && upd_is_branch && !stall;
        fill_we = br_upd && upd_taken;
        meta_we = (br_upd && (u_hit || upd_taken)) ||
                  (upd_valid && !upd_is_branch && upd_prev_taken && !stall && u_hit);
        meta_d  = !upd_is_branch ? btb_meta_t'{1'b0, meta_q[u_idx].ctr}
                : u_hit          ? btb_meta_t'{1'b1, ctr_nxt}
                :                  btb_meta_t'{1'b1, CTR_ALLOC};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) meta_q[i] <= btb_meta_t'{1'b0, CTR_RESET};
        end else if (meta_we) begin
            meta_q[u_idx] <= meta_d;
        end
    end

    // Tag/target need no reset: they are only observed through a set valid bit.
    always_ff @(posedge clk) begin
        if (fill_we) begin
            tag_q[u_idx] <= u_tag;
            tgt_q[u_idx] <= upd_target;
        end
    end

`ifdef BTB_STATS_EN
    logic [31:0] lookups_q, mispred_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lookups_q <= '0;
            mispred_q <= '0;
        end else if (!stall) begin
            if (lookups_q != 32'hFFFF_FFFF) lookups_q <= lookups_q + 32'd1;
            if (flush && mispred_q != 32'hFFFF_FFFF) mispred_q <= mispred_q + 32'd1;
        end
    end

    assign stat_lookups     = lookups_q;
    assign stat_mispredicts = mispred_q;
`else
    assign stat_lookups     = '0;
    assign stat_mispredicts = '0;
`endif

endmodule

// File: tb/tb_branch_target_buffer.sv
// tb_branch_target_buffer: directed vectors with a queue-based scoreboard for branch_target_buffer.
module tb_branch_target_buffer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic [31:0] lookup_pc = '0;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        upd_valid = 1'b0, upd_is_branch = 1'b0, upd_taken = 1'b0, upd_prev_taken = 1'b0;
    logic [31:0] upd_pc = '0, upd_target = '0, upd_pred_target = '0;
    logic        flush;
    logic [31:0] redirect_pc, stat_lookups, stat_mispredicts;

    always #5 clk = ~clk;

    branch_target_buffer #(.PC_W(32), .ENTRIES(16)) dut (
        .clk             (clk),
        .rst             (rst),
        .stall           (stall),
        .lookup_pc       (lookup_pc),
        .pred_taken      (pred_taken),
        .pred_target     (pred_target),
        .upd_valid       (upd_valid),
        .upd_is_branch   (upd_is_branch),
        .upd_pc          (upd_pc),
        .upd_target      (upd_target),
        .upd_taken       (upd_taken),
        .upd_prev_taken  (upd_prev_taken),
        .upd_pred_target (upd_pred_target),
        .flush           (flush),
        .redirect_pc     (redirect_pc),
        .stat_lookups    (stat_lookups),
        .stat_mispredicts(stat_mispredicts)
    );

    typedef struct {
        string       name;
        logic        pt;
        logic [31:0] ptgt;
        logic        fl;
        logic [31:0] rd;
        logic [31:0] sl;
        logic [31:0] sm;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] m_lk = '0, m_mp = '0;

    task automatic chk(input string nm, input string field, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s.%s: got %h expected %h", nm, field, act, req);
        end
    endtask

    // Monitor: each vector presents one response, sampled mid-cycle.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            chk(e.name, "pred_taken", {31'd0, pred_taken}, {31'd0, e.pt});
            chk(e.name, "pred_target", pred_target, e.ptgt);
            chk(e.name, "flush", {31'd0, flush}, {31'd0, e.fl});
            chk(e.name, "redirect_pc", redirect_pc, e.rd);
            chk(e.name, "stat_lookups", stat_lookups, e.sl);
            chk(e.name, "stat_mispredicts", stat_mispredicts, e.sm);
        end
    end

    task automatic vec(input string nm, input logic r, input logic st, input logic [31:0] lpc,
                       input logic uv, input logic ub, input logic [31:0] upc, input logic [31:0] utgt,
                       input logic ut, input logic upt, input logic [31:0] uptgt,
                       input logic ept, input logic [31:0] eptgt, input logic efl, input logic [31:0] erd);
        exp_t e;
        rst = r; stall = st; lookup_pc = lpc;
        upd_valid = uv; upd_is_branch = ub; upd_pc = upc; upd_target = utgt;
        upd_taken = ut; upd_prev_taken = upt; upd_pred_target = uptgt;
        if (r) begin m_lk = '0; m_mp = '0; end
        e.name = nm; e.pt = ept; e.ptgt = eptgt; e.fl = efl; e.rd = erd;
`ifdef BTB_STATS_EN
        e.sl = m_lk; e.sm = m_mp;
`else
        e.sl = '0; e.sm = '0;
`endif
        sb.push_back(e);
        if (!r && !st) begin
            m_lk = m_lk + 1;
            if (efl) m_mp = m_mp + 1;
        end
        @(posedge clk); #1;
    endtask

    task automatic idle(input string nm, input logic [31:0] lpc, input logic ept, input logic [31:0] eptgt);
        vec(nm, 1'b0, 1'b0, lpc, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, ept, eptgt, 1'b0, 32'h4);
    endtask

    initial begin
        @(posedge clk); #1;
        // name           rst st lookup        uv ub upc          utgt         ut upt uptgt        ept eptgt        efl erd
        vec("rst_upd",    1, 0, 32'h100,       1, 1, 32'h100,     32'h200,     1, 0, 32'h104,     0, 32'h104,      1, 32'h200);
        idle("after_rst", 32'h100, 0, 32'h104);
        vec("alloc",      0, 0, 32'h100,       1, 1, 32'h100,     32'h200,     1, 0, 32'h104,     0, 32'h104,      1, 32'h200);
        idle("alloc_hit", 32'h100, 1, 32'h200);
        vec("nt1",        0, 0, 32'h100,       1, 1, 32'h100,     32'h200,     0, 1, 32'h200,     1, 32'h200,      1, 32'h104);
        vec("nt2",        0, 0, 32'h100,       1, 1, 32'h100,     32'h200,     0, 0, 32'h104,     0, 32'h200,      0, 32'h104);
        vec("nt3",        0, 0, 32'h100,       1, 1, 32'h100,     32'h200,     0, 0, 32'h104,     0, 32'h200,      0, 32'h104);
        vec("nt4",        0, 0, 32'h100,       1, 1, 32'h100,     32'h200,     0, 0, 32'h104,     0, 32'h200,      0, 32'h104);
        vec("t_from_snt", 0, 0, 32'h100,       1, 1, 32'h100,     32'h200,     1, 0, 32'h104,     0, 32'h200,      1, 32'h200);
        idle("no_uflow",  32'h100, 0, 32'h200);
        vec("t_to_wt",    0, 0, 32'h100,       1, 1, 32'h100,     32'h200,     1, 0, 32'h104,     0, 32'h200,      1, 32'h200);
        idle("wt_hit",    32'h100, 1, 32'h200);
        vec("tgt_change", 0, 0, 32'h100,       1, 1, 32'h100,     32'h300,     1, 1, 32'h200,     1, 32'h200,      1, 32'h300);
        idle("new_tgt",   32'h100, 1, 32'h300);
        vec("stall_upd",  0, 1, 32'h100,       1, 1, 32'h100,     32'h300,     0, 1, 32'h300,     1, 32'h300,      1, 32'h104);
        idle("stall_keep",32'h100, 1, 32'h300);
        vec("correct",    0, 0, 32'h100,       1, 1, 32'h100,     32'h300,     1, 1, 32'h300,     1, 32'h300,      0, 32'h300);
        vec("alias_alloc",0, 0, 32'h140,       1, 1, 32'h140,     32'h400,     1, 0, 32'h144,     0, 32'h144,      1, 32'h400);
        idle("old_miss",  32'h100, 0, 32'h104);
        idle("new_hit",   32'h140, 1, 32'h400);
        vec("miss_nt",    0, 0, 32'h140,       1, 1, 32'h180,     32'h999,     0, 0, 32'h184,     1, 32'h400,      0, 32'h184);
        idle("miss_nt_k", 32'h140, 1, 32'h400);
        idle("miss_nt_m", 32'h180, 0, 32'h184);
        vec("evict_stall",0, 1, 32'h140,       1, 0, 32'h140,     32'h0,       0, 1, 32'h400,     1, 32'h400,      1, 32'h144);
        idle("evict_held",32'h140, 1, 32'h400);
        vec("evict",      0, 0, 32'h140,       1, 0, 32'h140,     32'h0,       0, 1, 32'h400,     1, 32'h400,      1, 32'h144);
        idle("evicted",   32'h140, 0, 32'h144);
        vec("nonbr_ok",   0, 0, 32'h500,       1, 0, 32'h500,     32'h0,       0, 0, 32'h504,     0, 32'h504,      0, 32'h504);
        vec("wrap",       0, 0, 32'hFFFFFFFC,  1, 0, 32'hFFFFFFFC,32'h0,       0, 1, 32'h0,       0, 32'h0,        1, 32'h0);
        vec("idx1_alloc", 0, 0, 32'h104,       1, 1, 32'h104,     32'h800,     1, 0, 32'h108,     0, 32'h108,      1, 32'h800);
        idle("idx1_hit",  32'h104, 1, 32'h800);
        vec("rst_mid",    1, 0, 32'h104,       1, 1, 32'h108,     32'h900,     1, 0, 32'h10C,     0, 32'h108,      1, 32'h900);
        idle("rst_clr1",  32'h104, 0, 32'h108);
        idle("rst_disc",  32'h108, 0, 32'h10C);
        for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d responses outstanding, expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
